// File: rtl/pif_ram_port_arbiter_if.sv
// Bundle of requester, RAM and error signals around the PIF RAM CPU-side port arbiter.
// Handshake: a requester holds req (with addr/wr/wdata stable) until completion (cpu_ready high
// with cpu_req high, or dma_ack) and must drop or change it at the edge ending that cycle;
// the RAM holds mem_valid for the cycle in which mem_q is valid while mem_oe is high.
interface pif_ram_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ready;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_wr;
  logic [7:0]        dma_wdata;
  logic [7:0]        dma_rdata;
  logic              dma_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_oe;
  logic              mem_wren;
  logic [7:0]        mem_data;
  logic [7:0]        mem_q;
  logic              mem_valid;
  logic              err_clr;
  logic              timeout_err;

  // master: requesters, RAM and control environment; slave: the arbiter itself
  modport master (
    output cpu_req, cpu_addr, cpu_wr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_addr, dma_wr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_addr, mem_oe, mem_wren, mem_data,
    output mem_q, mem_valid,
    output err_clr,
    input  timeout_err
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_addr, dma_wr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_addr, mem_oe, mem_wren, mem_data,
    input  mem_q, mem_valid,
    input  err_clr,
    output timeout_err
  );
endinterface

// File: rtl/pif_ram_port_arbiter.sv
// Arbitrates the PIF RAM CPU-side byte port between the 6502 CPU and the joybus DMA engine,
// one access at a time, with a per-access timeout and a sticky timeout error flag.
module pif_ram_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT      = 255,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_l,
  pif_ram_port_arbiter_if.slave     bus,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_cpu;
  logic              wr_q;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        dma_rdata_q;
  logic              err_q;

  logic              take;
  logic              pick_cpu;
  logic              done;
  logic              timed_out;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick_cpu  = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          take = 1'b1;
          // grant_cpu doubles as last_grant once the previous access is over
          if (bus.cpu_req && bus.dma_req) pick_cpu = CPU_PRIORITY ? 1'b1 : !grant_cpu;
          else                            pick_cpu = bus.cpu_req;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.mem_valid) begin
          done      = 1'b1;
          state_nxt = S_RESP;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= S_IDLE;
      grant_cpu   <= 1'b0;
      wr_q        <= 1'b0;
      cnt         <= 8'd0;
      mem_addr_q  <= '0;
      mem_data_q  <= 8'd0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant_cpu  <= pick_cpu;
        wr_q       <= pick_cpu ? bus.cpu_wr    : bus.dma_wr;
        mem_addr_q <= pick_cpu ? bus.cpu_addr  : bus.dma_addr;
        mem_data_q <= pick_cpu ? bus.cpu_wdata : bus.dma_wdata;
        cnt        <= 8'd0;
      end else if (state == S_ACCESS) begin
        cnt <= cnt + 8'd1;
      end
      if (done && !wr_q) begin
        if (grant_cpu) cpu_rdata_q <= bus.mem_q;
        else           dma_rdata_q <= bus.mem_q;
      end
      if (timed_out) begin
        if (grant_cpu) cpu_rdata_q <= 8'hFF;
        else           dma_rdata_q <= 8'hFF;
      end
      // a timeout on the same edge as err_clr keeps the flag set
      if (timed_out)        err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_oe      = (state == S_ACCESS);
  assign bus.mem_wren    = (state == S_ACCESS) && wr_q && (cnt == 8'd0);
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign bus.cpu_ready   = !bus.cpu_req || ((state == S_RESP) && grant_cpu);
  assign bus.dma_ack     = (state == S_RESP) && !grant_cpu;
  assign bus.timeout_err = err_q;
  assign dbg_state       = state;

endmodule
